imm_decode_stage: RTL and testbench
===================================

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, immediate width; legal values 32 and 64.
REQ-002 SHALL have parameter TAG_W, default 64, width of sideband tag (PC) carried with each instruction.
REQ-003 SHALL have port i_clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port i_valid, input, 1, upstream instruction valid.
REQ-006 SHALL have port o_ready, output, 1, stage can accept an instruction.
REQ-007 SHALL have port i_inst, input, 32, raw instruction word.
REQ-008 SHALL have port i_tag, input, TAG_W, sideband passed through unchanged.
REQ-009 SHALL have port o_valid, output, 1, decoded result valid.
REQ-010 SHALL have port i_ready, input, 1, downstream accepts result.
REQ-011 SHALL have port o_imm, output, XLEN, sign-extended immediate.
REQ-012 SHALL have port o_type, output, 6, one-hot format [5:0]={r,i,s,b,u,j}; all-zero when illegal.
REQ-013 SHALL have port o_illegal, output, 1, opcode unrecognised.
REQ-014 SHALL have port o_inst, output, 32, and o_tag, output, TAG_W, instruction and tag of the presented result.
REQ-015 SHALL have port o_illegal_cnt, output, 16, saturating count of accepted illegal instructions.

Function
REQ-016 SHALL accept an input when i_valid && o_ready; SHALL present a result when o_valid; SHALL retire it when o_valid && i_ready.
REQ-017 SHALL decode opcode i_inst[6:0]: 0110111/0010111 U; 1101111 J; 1100111, 0000011, 0010011, 0001111, 1110011 I; 1100011 B; 0100011 S; 0110011 R. 0011011 SHALL be I and 0111011 R when XLEN=64, illegal when XLEN=32.
REQ-018 SHALL treat every other opcode as illegal: o_type=0, o_imm=0, o_illegal=1.
REQ-019 SHALL form immediates: I sext(inst[31:20]); S sext({inst[31:25],inst[11:7]}); B sext({inst[31],inst[7],inst[30:25],inst[11:8],0}); U sext({inst[31:12],12'b0}); J sext({inst[31],inst[19:12],inst[20],inst[30:21],0}); R zero. Sign-extension SHALL use inst[31] up to bit XLEN-1.
REQ-020 SHALL register results: latency from accept to o_valid exactly 1 cycle.
REQ-021 SHALL contain one output register plus one skid register; o_ready SHALL be a register output equal to !skid_valid.
REQ-022 Output empty or retiring this cycle: accepted input SHALL load the output register.
REQ-023 Output full, not retiring, input accepted: input SHALL load the skid register; o_ready SHALL fall next cycle.
REQ-024 Skid full and output retiring: skid contents SHALL move to the output register and o_ready SHALL rise next cycle.
REQ-025 o_imm, o_type, o_illegal, o_inst, o_tag SHALL remain stable while o_valid && !i_ready.
REQ-026 Results SHALL leave in acceptance order; no loss or duplication.
REQ-027 o_illegal_cnt SHALL increment by 1 when an illegal instruction is accepted at input and SHALL hold at 16'hFFFF.

Reset
REQ-028 While i_rst_n=0 at a rising edge: o_valid=0, skid_valid=0, o_ready=1 after that edge, o_illegal_cnt=0, o_imm=0, o_type=0, o_illegal=0, o_inst=0, o_tag=0.
REQ-029 Reset mid-transfer SHALL discard output and skid contents with no result emitted.

Configuration
REQ-030 With IMM_DECODE_ZICSR_EN defined, opcode 1110011 with inst[14]=1 SHALL give o_imm=zext(inst[19:15]), o_type=i.
REQ-031 Without IMM_DECODE_ZICSR_EN, all opcode-1110011 instructions SHALL use the I-format immediate.

Verification
REQ-032 XLEN=64, 0xFFF00093 -> o_type=6'b010000, o_imm=0xFFFFFFFFFFFFFFFF, one cycle after accept.
REQ-033 XLEN=64, 0x800000B7 -> o_type=6'b000010, o_imm=0xFFFFFFFF80000000; 0xFE000EE3 -> b, o_imm=-4; 0x0010006F -> j, o_imm=0x800.
REQ-034 0x3002D073 -> o_imm=5 with IMM_DECODE_ZICSR_EN, o_imm=0x300 without.
REQ-035 Three back-to-back inputs, i_ready=0 for 3 cycles -> o_ready=0 after second accept, all three emerge in order, o_valid held stable.
REQ-036 0x00000000 accepted 70000 times -> each o_illegal=1, o_type=0, o_illegal_cnt stops at 0xFFFF; reset -> 0.

Source files
------------

// File: rtl/imm_decode_stage.sv
// Immediate-decode pipeline stage: registered decode with a one-entry skid buffer.
// Optional feature macro: IMM_DECODE_ZICSR_EN (CSR-immediate forms give zext(rs1) immediate).
module imm_decode_stage #(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned TAG_W = 64
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [31:0]      i_inst,
   input  logic [TAG_W-1:0] i_tag,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [XLEN-1:0]  o_imm,
   output logic [5:0]       o_type,
   output logic             o_illegal,
   output logic [31:0]      o_inst,
   output logic [TAG_W-1:0] o_tag,
   output logic [15:0]      o_illegal_cnt
);

   // One-hot format encoding {r,i,s,b,u,j}
   localparam logic [5:0] TypeR = 6'b100000;
   localparam logic [5:0] TypeI = 6'b010000;
   localparam logic [5:0] TypeS = 6'b001000;
   localparam logic [5:0] TypeB = 6'b000100;
   localparam logic [5:0] TypeU = 6'b000010;
   localparam logic [5:0] TypeJ = 6'b000001;

   logic [5:0]      dec_type;
   logic            dec_illegal;
   logic [31:0]     imm32;
   logic [XLEN-1:0] dec_imm;

   always_comb begin
      dec_type    = '0;
      dec_illegal = 1'b0;
      imm32       = '0;
      case (i_inst[6:0])
         7'b0110111, 7'b0010111: dec_type = TypeU;
         7'b1101111:             dec_type = TypeJ;
         7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011: dec_type = TypeI;
         7'b1100011:             dec_type = TypeB;
         7'b0100011:             dec_type = TypeS;
         7'b0110011:             dec_type = TypeR;
         7'b0011011: begin
            if (XLEN == 64) dec_type = TypeI;
            else            dec_illegal = 1'b1;
         end
         7'b0111011: begin
            if (XLEN == 64) dec_type = TypeR;
            else            dec_illegal = 1'b1;
         end
         default:                dec_illegal = 1'b1;
      endcase
      case (dec_type)
         TypeI:   imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
         TypeS:   imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
         TypeB:   imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                           i_inst[11:8], 1'b0};
         TypeU:   imm32 = {i_inst[31:12], 12'b0};
         TypeJ:   imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                           i_inst[30:21], 1'b0};
         default: imm32 = '0;
      endcase
`ifdef IMM_DECODE_ZICSR_EN
      if (i_inst[6:0] == 7'b1110011 && i_inst[14]) imm32 = {27'b0, i_inst[19:15]};
`else
`endif
      // Bit 31 of imm32 always equals inst[31] (or 0), so signed widening does the extension
      dec_imm = XLEN'($signed(imm32));
   end

   logic             out_valid_q, out_valid_d;
   logic [XLEN-1:0]  out_imm_q, out_imm_d;
   logic [5:0]       out_type_q, out_type_d;
   logic             out_ill_q, out_ill_d;
   logic [31:0]      out_inst_q, out_inst_d;
   logic [TAG_W-1:0] out_tag_q, out_tag_d;
   logic             skid_valid_q, skid_valid_d;
   logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
   logic [5:0]       skid_type_q, skid_type_d;
   logic             skid_ill_q, skid_ill_d;
   logic [31:0]      skid_inst_q, skid_inst_d;
   logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
   logic             ready_q, ready_d;
   logic [15:0]      cnt_q, cnt_d;
   logic             accept, retire;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_imm_d    = out_imm_q;
      out_type_d   = out_type_q;
      out_ill_d    = out_ill_q;
      out_inst_d   = out_inst_q;
      out_tag_d    = out_tag_q;
      skid_valid_d = skid_valid_q;
      skid_imm_d   = skid_imm_q;
      skid_type_d  = skid_type_q;
      skid_ill_d   = skid_ill_q;
      skid_inst_d  = skid_inst_q;
      skid_tag_d   = skid_tag_q;
      cnt_d        = cnt_q;
      accept       = i_valid && ready_q;
      retire       = out_valid_q && i_ready;

      // Skid can only be full while the output is full, so accept never coincides with drain
      if (!out_valid_q || retire) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_imm_d    = skid_imm_q;
            out_type_d   = skid_type_q;
            out_ill_d    = skid_ill_q;
            out_inst_d   = skid_inst_q;
            out_tag_d    = skid_tag_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            out_valid_d = 1'b1;
            out_imm_d   = dec_imm;
            out_type_d  = dec_type;
            out_ill_d   = dec_illegal;
            out_inst_d  = i_inst;
            out_tag_d   = i_tag;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_imm_d   = dec_imm;
         skid_type_d  = dec_type;
         skid_ill_d   = dec_illegal;
         skid_inst_d  = i_inst;
         skid_tag_d   = i_tag;
      end

      ready_d = !skid_valid_d;
      if (accept && dec_illegal && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         out_valid_q  <= 1'b0;
         out_imm_q    <= '0;
         out_type_q   <= '0;
         out_ill_q    <= 1'b0;
         out_inst_q   <= '0;
         out_tag_q    <= '0;
         skid_valid_q <= 1'b0;
         skid_imm_q   <= '0;
         skid_type_q  <= '0;
         skid_ill_q   <= 1'b0;
         skid_inst_q  <= '0;
         skid_tag_q   <= '0;
         ready_q      <= 1'b1;
         cnt_q        <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_imm_q    <= out_imm_d;
         out_type_q   <= out_type_d;
         out_ill_q    <= out_ill_d;
         out_inst_q   <= out_inst_d;
         out_tag_q    <= out_tag_d;
         skid_valid_q <= skid_valid_d;
         skid_imm_q   <= skid_imm_d;
         skid_type_q  <= skid_type_d;
         skid_ill_q   <= skid_ill_d;
         skid_inst_q  <= skid_inst_d;
         skid_tag_q   <= skid_tag_d;
         ready_q      <= ready_d;
         cnt_q        <= cnt_d;
      end
   end

   assign o_ready       = ready_q;
   assign o_valid       = out_valid_q;
   assign o_imm         = out_imm_q;
   assign o_type        = out_type_q;
   assign o_illegal     = out_ill_q;
   assign o_inst        = out_inst_q;
   assign o_tag         = out_tag_q;
   assign o_illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: vector table, directed skid/reset sequences, random traffic
// against a queue-based reference model.
module tb_imm_decode_stage;
   localparam int XLEN  = 64;
   localparam int TAG_W = 64;
   localparam logic [5:0] TR = 6'b100000, TI = 6'b010000, TS = 6'b001000;
   localparam logic [5:0] TB = 6'b000100, TU = 6'b000010, TJ = 6'b000001;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             i_valid, i_ready, o_ready, o_valid, o_illegal;
   logic [31:0]      i_inst, o_inst;
   logic [TAG_W-1:0] i_tag, o_tag;
   logic [XLEN-1:0]  o_imm;
   logic [5:0]       o_type;
   logic [15:0]      o_illegal_cnt;

   imm_decode_stage #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_inst(i_inst), .i_tag(i_tag), .o_valid(o_valid), .i_ready(i_ready),
      .o_imm(o_imm), .o_type(o_type), .o_illegal(o_illegal), .o_inst(o_inst),
      .o_tag(o_tag), .o_illegal_cnt(o_illegal_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]      inst;
      logic [TAG_W-1:0] tag;
   } item_t;

   typedef struct {
      logic [31:0] inst;
      logic [5:0]  ty;
      logic [63:0] imm;
      logic        ill;
   } vec_t;

   int total = 0;
   int bad = 0;
   item_t q[$];
   int model_cnt = 0;
   bit hold_pending = 0;
   logic [63:0] h_imm, h_tag;
   logic [5:0]  h_type;
   logic        h_ill;
   logic [31:0] h_inst;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Reference decode: immediates as signed arithmetic sums of the instruction fields
   function automatic void ref_decode(input logic [31:0] inst, output logic [5:0] ty,
                                      output logic [63:0] imm, output logic ill);
      longint v;
      longint s;
      s   = longint'(inst[31]);
      ty  = 6'b0;
      ill = 1'b0;
      v   = 0;
      case (inst[6:0])
         7'b0110111, 7'b0010111: ty = TU;
         7'b1101111: ty = TJ;
         7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011, 7'b0011011: ty = TI;
         7'b1100011: ty = TB;
         7'b0100011: ty = TS;
         7'b0110011, 7'b0111011: ty = TR;
         default: ill = 1'b1;
      endcase
      if (ty == TI) v = -s * 2048 + longint'(inst[30:20]);
      if (ty == TS) v = -s * 2048 + longint'(inst[30:25]) * 32 + longint'(inst[11:7]);
      if (ty == TB) v = -s * 4096 + longint'(inst[7]) * 2048 + longint'(inst[30:25]) * 32
                        + longint'(inst[11:8]) * 2;
      if (ty == TU) v = -s * 64'sh80000000 + longint'(inst[30:12]) * 4096;
      if (ty == TJ) v = -s * 1048576 + longint'(inst[19:12]) * 4096
                        + longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2;
`ifdef IMM_DECODE_ZICSR_EN
      if (inst[6:0] == 7'b1110011 && inst[14]) v = longint'(inst[19:15]);
`endif
      imm = v;
   endfunction

   // One clock cycle, entered and left at a falling edge; checks DUT against the model
   task automatic step(input logic v, input logic [31:0] inst, input logic [TAG_W-1:0] tag,
                       input logic rdy, output bit acc);
      item_t       it;
      logic [5:0]  ety;
      logic [63:0] eimm;
      logic        eill;
      chk("o_valid", o_valid, q.size() != 0);
      chk("o_ready", o_ready, q.size() < 2);
      chk("illegal_cnt", o_illegal_cnt, model_cnt);
      if (hold_pending) begin
         chk("hold_imm", o_imm, h_imm);
         chk("hold_type", o_type, h_type);
         chk("hold_ill", o_illegal, h_ill);
         chk("hold_inst", o_inst, h_inst);
         chk("hold_tag", o_tag, h_tag);
      end
      i_valid = v;
      i_inst  = inst;
      i_tag   = tag;
      i_ready = rdy;
      acc = v && o_ready;
      if (o_valid && rdy) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL retire_empty: got o_valid=1 want no pending result");
         end else begin
            it = q.pop_front();
            ref_decode(it.inst, ety, eimm, eill);
            chk("out_inst", o_inst, it.inst);
            chk("out_tag", o_tag, it.tag);
            chk("out_imm", o_imm, eimm);
            chk("out_type", o_type, ety);
            chk("out_ill", o_illegal, eill);
         end
      end
      hold_pending = o_valid && !rdy;
      h_imm = o_imm; h_type = o_type; h_ill = o_illegal; h_inst = o_inst; h_tag = o_tag;
      if (acc) begin
         it.inst = inst;
         it.tag  = tag;
         q.push_back(it);
         ref_decode(inst, ety, eimm, eill);
         if (eill && model_cnt < 65535) model_cnt++;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      q.delete();
      model_cnt    = 0;
      hold_pending = 0;
   endtask

   task automatic drain();
      bit acc;
      for (int k = 0; k < 6 && q.size() != 0; k++) step(1'b0, 32'h0, '0, 1'b1, acc);
      chk("drain_empty", q.size(), 0);
   endtask

   vec_t vecs[12];
   logic [6:0] ops[14];

   initial begin
      bit acc;
      logic [31:0] r;
      vecs[0]  = '{32'hFFF00093, TI, 64'hFFFFFFFFFFFFFFFF, 1'b0};
      vecs[1]  = '{32'h800000B7, TU, 64'hFFFFFFFF80000000, 1'b0};
      vecs[2]  = '{32'hFE000EE3, TB, 64'hFFFFFFFFFFFFFFFC, 1'b0};
      vecs[3]  = '{32'h0010006F, TJ, 64'h0000000000000800, 1'b0};
`ifdef IMM_DECODE_ZICSR_EN
      vecs[4]  = '{32'h3002D073, TI, 64'h5, 1'b0};
`else
      vecs[4]  = '{32'h3002D073, TI, 64'h300, 1'b0};
`endif
      vecs[5]  = '{32'hFE112E23, TS, 64'hFFFFFFFFFFFFFFFC, 1'b0};
      vecs[6]  = '{32'h00B50533, TR, 64'h0, 1'b0};
      vecs[7]  = '{32'h0010009B, TI, 64'h1, 1'b0};
      vecs[8]  = '{32'hFFF0003B, TR, 64'h0, 1'b0};
      vecs[9]  = '{32'h00000000, 6'b0, 64'h0, 1'b1};
      vecs[10] = '{32'hFFFFFFFF, 6'b0, 64'h0, 1'b1};
      vecs[11] = '{32'h7FFFF017, TU, 64'h7FFFF000, 1'b0};
      ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011, 7'b0010011,
              7'b0001111, 7'b1110011, 7'b1100011, 7'b0100011, 7'b0110011, 7'b0011011,
              7'b0111011, 7'b1111111};

      rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_inst = '0; i_tag = '0;
      @(negedge clk);
      do_reset();
      chk("rst_valid", o_valid, 0);
      chk("rst_ready", o_ready, 1);
      chk("rst_cnt", o_illegal_cnt, 0);
      chk("rst_imm", o_imm, 0);
      chk("rst_type", o_type, 0);
      chk("rst_ill", o_illegal, 0);
      chk("rst_inst", o_inst, 0);
      chk("rst_tag", o_tag, 0);

      // Table vectors: each result must be presented exactly one cycle after accept
      for (int i = 0; i < 12; i++) begin
         step(1'b1, vecs[i].inst, 64'(i) + 64'h100, 1'b1, acc);
         chk("tbl_accept", acc, 1);
         chk("tbl_valid", o_valid, 1);
         chk("tbl_type", o_type, vecs[i].ty);
         chk("tbl_imm", o_imm, vecs[i].imm);
         chk("tbl_ill", o_illegal, vecs[i].ill);
         chk("tbl_inst", o_inst, vecs[i].inst);
      end
      drain();

      // Back-to-back with downstream stalled three cycles: second accept fills the skid
      step(1'b1, 32'hFFF00093, 64'hA, 1'b0, acc);
      step(1'b1, 32'h800000B7, 64'hB, 1'b0, acc);
      chk("skid_ready_low", o_ready, 0);
      step(1'b1, 32'h0010006F, 64'hC, 1'b0, acc);
      chk("skid_no_accept", acc, 0);
      acc = 0;
      for (int k = 0; k < 8 && !acc; k++) step(1'b1, 32'h0010006F, 64'hC, 1'b1, acc);
      chk("third_accepted", acc, 1);
      drain();

      // Reset with both registers full discards everything
      step(1'b1, 32'h00000013, 64'h1, 1'b0, acc);
      step(1'b1, 32'h00000000, 64'h2, 1'b0, acc);
      do_reset();
      chk("midrst_valid", o_valid, 0);
      chk("midrst_ready", o_ready, 1);
      chk("midrst_cnt", o_illegal_cnt, 0);
      chk("midrst_inst", o_inst, 0);
      for (int k = 0; k < 3; k++) step(1'b0, 32'h0, '0, 1'b1, acc);

      for (int n = 0; n < 3000; n++) begin
         r = $urandom;
         r[6:0] = ($urandom_range(0, 4) == 0) ? 7'($urandom) : ops[$urandom_range(0, 13)];
         step($urandom_range(0, 3) != 0, r, {$urandom, $urandom}, $urandom_range(0, 2) != 0,
              acc);
      end
      drain();

      // Saturation of the illegal counter
      for (int n = 0; n < 70000; n++) step(1'b1, 32'h0, 64'(n), 1'b1, acc);
      drain();
      chk("cnt_saturated", o_illegal_cnt, 16'hFFFF);
      do_reset();
      chk("cnt_after_reset", o_illegal_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
